// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
// Contents: hold-level codes driven on hold_flag, jump/reset enable levels,
// controller state encoding and a helper that picks the stronger hold level.
package pipe_ctrl_pkg;

  // Hold levels: a higher code freezes more of the front end.
  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic JUMP_ENABLE  = 1'b1;
  localparam logic JUMP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Returns the stronger of two hold levels.
  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// hold_watchdog: counts consecutive bus-hold cycles and flags a bus timeout.
// Ports:
//   clk          in  1  clock, posedge
//   rst          in  1  synchronous active-high reset
//   rib_hold_req in  1  bus busy stall request
//   bus_timeout  out 1  registered one-cycle pulse when the run length hits BUS_TMO
module hold_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int BUS_TMO = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic rib_hold_req,
  output logic bus_timeout
);

  localparam logic [7:0] TMO = 8'(BUS_TMO);

  logic [7:0] cnt;
  logic [7:0] cnt_next;

  // Next run length: saturating increment while held, cleared otherwise.
  always_comb begin
    cnt_next = 8'd0;
    if (rib_hold_req) begin
      cnt_next = (cnt == 8'hFF) ? cnt : (cnt + 8'd1);
    end else begin
      cnt_next = 8'd0;
    end
  end

  // Counter register and edge-detected timeout pulse; saturation keeps
  // the pulse from repeating while the bus stays held.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt         <= 8'd0;
      bus_timeout <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      bus_timeout <= rib_hold_req && (cnt_next == TMO) && (cnt != TMO);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold / jump / halt controller.
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   ex_jump_req, ex_jump_addr[31:0]  execute-stage jump request and target
//   ex_hold_req                      execute multi-cycle stall
//   rib_hold_req                     bus busy stall
//   clint_int_req, clint_int_addr    interrupt entry request and handler address
//   clint_hold_req                   interrupt context-save stall
//   jtag_halt_req                    debugger halt (level)
//   jump_flag, jump_addr[31:0]       registered jump to the PC register
//   hold_flag[2:0]                   combinational hold level to pipeline regs
//   halted                           registered halt acknowledge
//   bus_timeout                      one-cycle bus timeout pulse
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN = 2,
  parameter int BUS_TMO   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_req,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_hold_req,
  input  logic        rib_hold_req,
  input  logic        clint_int_req,
  input  logic [31:0] clint_int_addr,
  input  logic        clint_hold_req,
  input  logic        jtag_halt_req,
  output logic        jump_flag,
  output logic [31:0] jump_addr,
  output logic [2:0]  hold_flag,
  output logic        halted,
  output logic        bus_timeout
);

  localparam int CW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_LEN - 1);

  state_t        state;
  logic [CW-1:0] flush_cnt;
  logic          pend_valid;
  logic [31:0]   pend_addr;

  logic          req_valid;
  logic [31:0]   req_addr;
  logic [31:0]   pend_next;
  logic [2:0]    lvl_id;
  logic [2:0]    lvl_if;
  logic [2:0]    lvl_pc;

  // Interrupt wins over an execute jump; an interrupt also overwrites a pending target.
  always_comb begin
    req_valid = clint_int_req || ex_jump_req;
    req_addr  = clint_int_req ? clint_int_addr : ex_jump_addr;
    pend_next = clint_int_req ? clint_int_addr : pend_addr;
  end

  // Hold level is the maximum of all contributions; state-derived terms are
  // masked while reset is asserted so only live input requests can hold.
  always_comb begin
    lvl_id = (ex_hold_req || clint_hold_req ||
              (!rst && ((state == ST_HALT) || jump_flag))) ? HOLD_ID : HOLD_NONE;
    lvl_if = (!rst && (state == ST_FLUSH)) ? HOLD_IF : HOLD_NONE;
    lvl_pc = rib_hold_req ? HOLD_PC : HOLD_NONE;
    hold_flag = hold_max(lvl_id, hold_max(lvl_if, lvl_pc));
  end

  // Controller FSM with registered jump/halt outputs.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= ST_RUN;
      flush_cnt  <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      jump_flag  <= JUMP_DISABLE;
      jump_addr  <= 32'd0;
      halted     <= 1'b0;
    end else begin
      jump_flag <= JUMP_DISABLE;
      case (state)
        ST_RUN: begin
          if (jump_flag) begin
            // Issuing cycle: start the flush; only interrupts are kept.
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_INIT;
            if (clint_int_req) begin
              pend_valid <= 1'b1;
              pend_addr  <= clint_int_addr;
            end else begin
              pend_valid <= pend_valid;
            end
          end else if (pend_valid) begin
            // Pending jump: later execute jumps are dropped, interrupts overwrite.
            if (!rib_hold_req) begin
              jump_flag  <= JUMP_ENABLE;
              jump_addr  <= pend_next;
              pend_valid <= 1'b0;
            end else begin
              pend_addr <= pend_next;
            end
          end else if (req_valid) begin
            if (!rib_hold_req) begin
              jump_flag <= JUMP_ENABLE;
              jump_addr <= req_addr;
            end else begin
              pend_valid <= 1'b1;
              pend_addr  <= req_addr;
            end
          end else if (jtag_halt_req) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_RUN;
            // A latched (or just-arriving) interrupt issues directly on exit.
            if ((pend_valid || clint_int_req) && !rib_hold_req) begin
              jump_flag  <= JUMP_ENABLE;
              jump_addr  <= pend_next;
              pend_valid <= 1'b0;
            end else if (clint_int_req) begin
              pend_valid <= 1'b1;
              pend_addr  <= clint_int_addr;
            end else begin
              pend_valid <= pend_valid;
            end
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
            if (clint_int_req) begin
              pend_valid <= 1'b1;
              pend_addr  <= clint_int_addr;
            end else begin
              pend_valid <= pend_valid;
            end
          end
        end
        ST_HALT: begin
          if (!jtag_halt_req) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end else begin
            halted <= 1'b1;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  hold_watchdog #(
    .BUS_TMO(BUS_TMO)
  ) u_hold_watchdog (
    .clk          (clk),
    .rst          (rst),
    .rib_hold_req (rib_hold_req),
    .bus_timeout  (bus_timeout)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven bench for pipe_ctrl plus hand-written
// bus-timeout sequences.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_jump_req;
  logic [31:0] ex_jump_addr;
  logic        ex_hold_req;
  logic        rib_hold_req;
  logic        clint_int_req;
  logic [31:0] clint_int_addr;
  logic        clint_hold_req;
  logic        jtag_halt_req;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic        halted;
  logic        bus_timeout;

  int checks;
  int errors;

  typedef struct {
    logic        r;
    logic        ej;
    logic [31:0] ea;
    logic        eh;
    logic        rb;
    logic        cj;
    logic [31:0] ca;
    logic        ch;
    logic        jt;
    logic        xjf;
    logic [31:0] xja;
    logic [2:0]  xh;
    logic        xhl;
  } vec_t;

  vec_t vecs[$];

  pipe_ctrl #(.FLUSH_LEN(2), .BUS_TMO(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_jump_req    (ex_jump_req),
    .ex_jump_addr   (ex_jump_addr),
    .ex_hold_req    (ex_hold_req),
    .rib_hold_req   (rib_hold_req),
    .clint_int_req  (clint_int_req),
    .clint_int_addr (clint_int_addr),
    .clint_hold_req (clint_hold_req),
    .jtag_halt_req  (jtag_halt_req),
    .jump_flag      (jump_flag),
    .jump_addr      (jump_addr),
    .hold_flag      (hold_flag),
    .halted         (halted),
    .bus_timeout    (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic ej, input logic [31:0] ea,
                              input logic eh, input logic rb, input logic cj,
                              input logic [31:0] ca, input logic ch, input logic jt,
                              input logic xjf, input logic [31:0] xja,
                              input logic [2:0] xh, input logic xhl);
    vec_t v;
    v.r = r; v.ej = ej; v.ea = ea; v.eh = eh; v.rb = rb; v.cj = cj; v.ca = ca;
    v.ch = ch; v.jt = jt; v.xjf = xjf; v.xja = xja; v.xh = xh; v.xhl = xhl;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_jump_req = 1'b0; ex_jump_addr = 32'd0; ex_hold_req = 1'b0;
    rib_hold_req = 1'b0; clint_int_req = 1'b0; clint_int_addr = 32'd0;
    clint_hold_req = 1'b0; jtag_halt_req = 1'b0;
  endtask

  int pulses;
  int pulse_at;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);

    //             r ej ea        eh rb cj ca        ch jt | jf ja        hold hl
    vecs.push_back(mk(1,0,32'h000,0,0,0,32'h000,0,0, 0,32'h000,3'd0,0)); // 0 reset
    vecs.push_back(mk(0,1,32'h100,0,0,0,32'h000,0,0, 0,32'h000,3'd0,0)); // 1 jump req
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 1,32'h100,3'd3,0)); // 2 issue
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h100,3'd2,0)); // 3 flush
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h100,3'd2,0)); // 4 flush
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h100,3'd0,0)); // 5 run
    vecs.push_back(mk(0,1,32'h300,0,0,1,32'h080,0,0, 0,32'h100,3'd0,0)); // 6 clint+ex
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 1,32'h080,3'd3,0)); // 7 clint wins
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h080,3'd2,0)); // 8 single pulse
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h080,3'd2,0)); // 9
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h080,3'd0,0)); // 10
    vecs.push_back(mk(0,1,32'h400,0,0,0,32'h000,0,0, 0,32'h080,3'd0,0)); // 11
    vecs.push_back(mk(0,1,32'h500,0,0,0,32'h000,0,0, 1,32'h400,3'd3,0)); // 12 ex ignored
    vecs.push_back(mk(0,1,32'h600,0,0,0,32'h000,0,0, 0,32'h400,3'd2,0)); // 13 ex ignored
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h400,3'd2,0)); // 14
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h400,3'd0,0)); // 15
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h400,3'd0,0)); // 16 no late jump
    vecs.push_back(mk(0,1,32'h700,0,0,0,32'h000,0,0, 0,32'h400,3'd0,0)); // 17
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 1,32'h700,3'd3,0)); // 18
    vecs.push_back(mk(0,0,32'h000,0,0,1,32'h090,0,0, 0,32'h700,3'd2,0)); // 19 clint in flush
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h700,3'd2,0)); // 20
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 1,32'h090,3'd3,0)); // 21 issue on exit
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h090,3'd2,0)); // 22
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h090,3'd2,0)); // 23
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h090,3'd0,0)); // 24
    vecs.push_back(mk(0,0,32'h000,0,1,0,32'h000,0,0, 0,32'h090,3'd1,0)); // 25 bus hold
    vecs.push_back(mk(0,1,32'h200,0,1,0,32'h000,0,0, 0,32'h090,3'd1,0)); // 26 pend
    vecs.push_back(mk(0,0,32'h000,0,1,0,32'h000,0,0, 0,32'h090,3'd1,0)); // 27
    vecs.push_back(mk(0,0,32'h000,0,1,0,32'h000,0,0, 0,32'h090,3'd1,0)); // 28
    vecs.push_back(mk(0,0,32'h000,0,1,0,32'h000,0,0, 0,32'h090,3'd1,0)); // 29
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h090,3'd0,0)); // 30 bus free
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 1,32'h200,3'd3,0)); // 31 pend issued
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h200,3'd2,0)); // 32
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h200,3'd2,0)); // 33
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h200,3'd0,0)); // 34
    vecs.push_back(mk(0,1,32'h210,0,1,0,32'h000,0,0, 0,32'h200,3'd1,0)); // 35 pend
    vecs.push_back(mk(0,1,32'h220,0,1,0,32'h000,0,0, 0,32'h200,3'd1,0)); // 36 ex dropped
    vecs.push_back(mk(0,0,32'h000,0,1,1,32'h0A0,0,0, 0,32'h200,3'd1,0)); // 37 clint overwrite
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h200,3'd0,0)); // 38
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 1,32'h0A0,3'd3,0)); // 39
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h0A0,3'd2,0)); // 40
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h0A0,3'd2,0)); // 41
    vecs.push_back(mk(0,0,32'h000,1,0,0,32'h000,0,0, 0,32'h0A0,3'd3,0)); // 42 ex hold
    vecs.push_back(mk(0,0,32'h000,0,1,0,32'h000,1,0, 0,32'h0A0,3'd3,0)); // 43 max of holds
    vecs.push_back(mk(0,0,32'h000,0,1,0,32'h000,0,0, 0,32'h0A0,3'd1,0)); // 44
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h0A0,3'd0,0)); // 45
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,1, 0,32'h0A0,3'd0,0)); // 46 halt req
    vecs.push_back(mk(0,1,32'h300,0,0,0,32'h000,0,1, 0,32'h0A0,3'd3,1)); // 47 halted
    vecs.push_back(mk(0,0,32'h000,0,1,1,32'h310,0,1, 0,32'h0A0,3'd3,1)); // 48 ignored
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h0A0,3'd3,1)); // 49 halt drop
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h0A0,3'd0,0)); // 50 resumed
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h0A0,3'd0,0)); // 51
    vecs.push_back(mk(0,1,32'h330,0,0,0,32'h000,0,1, 0,32'h0A0,3'd0,0)); // 52 jump vs halt
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,1, 1,32'h330,3'd3,0)); // 53
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,1, 0,32'h330,3'd2,0)); // 54
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,1, 0,32'h330,3'd2,0)); // 55
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,1, 0,32'h330,3'd0,0)); // 56
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h330,3'd3,1)); // 57
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h330,3'd0,0)); // 58
    vecs.push_back(mk(0,1,32'h440,0,0,0,32'h000,0,0, 0,32'h330,3'd0,0)); // 59
    vecs.push_back(mk(0,0,32'h000,0,0,1,32'h450,0,0, 1,32'h440,3'd3,0)); // 60 pend in issue
    vecs.push_back(mk(1,0,32'h000,1,0,0,32'h000,0,0, 0,32'h440,3'd3,0)); // 61 rst mid-flush
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h000,3'd0,0)); // 62 reset values
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h000,3'd0,0)); // 63 pend discarded
    vecs.push_back(mk(0,0,32'h000,0,0,0,32'h000,0,0, 0,32'h000,3'd0,0)); // 64

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst            = vecs[i].r;
      ex_jump_req    = vecs[i].ej;
      ex_jump_addr   = vecs[i].ea;
      ex_hold_req    = vecs[i].eh;
      rib_hold_req   = vecs[i].rb;
      clint_int_req  = vecs[i].cj;
      clint_int_addr = vecs[i].ca;
      clint_hold_req = vecs[i].ch;
      jtag_halt_req  = vecs[i].jt;
      #1;
      check("jump_flag",   i, {31'd0, jump_flag},   {31'd0, vecs[i].xjf});
      check("jump_addr",   i, jump_addr,            vecs[i].xja);
      check("hold_flag",   i, {29'd0, hold_flag},   {29'd0, vecs[i].xh});
      check("halted",      i, {31'd0, halted},      {31'd0, vecs[i].xhl});
      check("bus_timeout", i, {31'd0, bus_timeout}, 32'd0);
    end

    // Long bus hold: exactly one timeout pulse, after the 255th held cycle.
    @(posedge clk);
    #1;
    idle_inputs();
    rib_hold_req = 1'b1;
    pulses   = 0;
    pulse_at = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #2;
      if (bus_timeout === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("tmo_pulse_count", 0, pulses, 32'd1);
    check("tmo_pulse_cycle", 0, pulse_at, 32'd255);
    check("tmo_hold_flag",   0, {29'd0, hold_flag}, 32'd1);
    rib_hold_req = 1'b0;
    @(posedge clk);
    #2;
    check("tmo_after_release", 0, {31'd0, bus_timeout}, 32'd0);

    // Reset partway through a hold restarts the run count: no pulse in 200+200.
    rib_hold_req = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      rst = (i == 200) ? 1'b1 : 1'b0;
      #1;
      if (bus_timeout === 1'b1) begin
        pulses++;
      end
    end
    check("tmo_reset_clears", 0, pulses, 32'd0);
    rib_hold_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
